// File: rtl/usb_tx_pkg.sv
// usb_tx_pkg: shared types and constants for the USB full-speed TX bit encoder.
//   tx_state_e   encoder FSM states
//   line_t       {dp, dm} pair driven onto the bus
//   LINE_J/K/SE0 bus line levels
//   STUFF_LIMIT  run of ones that forces a stuffed zero
//   EOP_SE0_BITS bit times of SE0 at end of packet
package usb_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DATA    = 3'd1,
        ST_STUFF   = 3'd2,
        ST_EOP_SE0 = 3'd3,
        ST_EOP_J   = 3'd4,
        ST_DONE    = 3'd5
    } tx_state_e;

    typedef struct packed {
        logic dp;
        logic dm;
    } line_t;

    localparam line_t LINE_J   = '{dp: 1'b1, dm: 1'b0};
    localparam line_t LINE_K   = '{dp: 1'b0, dm: 1'b1};
    localparam line_t LINE_SE0 = '{dp: 1'b0, dm: 1'b0};

    localparam int STUFF_LIMIT  = 6;
    localparam int EOP_SE0_BITS = 2;

endpackage

// File: rtl/usb_tx_baud_tick.sv
// usb_tx_baud_tick: divides clk down to the USB bit rate.
//   clk, rst  system clock, synchronous active-high reset
//   clr       restarts the bit time (packet accept)
//   tick      high on the last clock of every bit time
module usb_tx_baud_tick #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int W = $clog2(CLKS_PER_BIT);

    logic [W-1:0] cnt;

    assign tick = (cnt == W'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk) begin
        if (rst || clr)
            cnt <= '0;
        else if (tick)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/usb_tx_bit_encoder.sv
// usb_tx_bit_encoder: serialises a compiled USB packet onto D+/D- with bit
// stuffing, NRZI encoding and EOP.
//   clk, rst                  system clock, synchronous active-high reset
//   packet_TX                 packet vector, bit 0 sent first
//   packet_counter_TX         valid bit count (clamped to MAX_BITS)
//   packet_load_complete_TX   start strobe, accepted only in IDLE
//   dp_out, dm_out, tx_oe     bus levels and driver enable
//   tx_busy, tx_done          status toward the TX control FSM
module usb_tx_bit_encoder
    import usb_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4,
    parameter int MAX_BITS     = 544,
    parameter int CNT_W        = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [MAX_BITS-1:0] packet_TX,
    input  logic [CNT_W-1:0]    packet_counter_TX,
    input  logic                packet_load_complete_TX,
    output logic                dp_out,
    output logic                dm_out,
    output logic                tx_oe,
    output logic                tx_busy,
    output logic                tx_done
);

    tx_state_e           state;
    logic [MAX_BITS-1:0] shift;
    logic [CNT_W-1:0]    len;
    logic [2:0]          ones;
    logic [1:0]          eop_cnt;
    logic                nrzi_j;   // level left by the previous bit, 1 = J

    logic                tick;
    logic                accept;
    logic [CNT_W-1:0]    len_in;
    logic [CNT_W-1:0]    len_m1;
    logic [2:0]          ones_nxt;
    logic                data_j;
    line_t               line;

    assign accept   = (state == ST_IDLE) && packet_load_complete_TX;
    assign len_in   = (packet_counter_TX > CNT_W'(MAX_BITS)) ? CNT_W'(MAX_BITS)
                                                            : packet_counter_TX;
    assign len_m1   = len - 1'b1;
    assign ones_nxt = shift[0] ? ones + 3'd1 : 3'd0;
    // NRZI: a one holds the previous level, a zero toggles it
    assign data_j   = shift[0] ? nrzi_j : ~nrzi_j;

    usb_tx_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk  (clk),
        .rst  (rst),
        .clr  (accept),
        .tick (tick)
    );

    // Line level is decoded from registered state so the first bit appears
    // the cycle after the strobe and holds for a full bit time.
    always_comb begin
        line = LINE_J;
        case (state)
            ST_DATA:    line = data_j  ? LINE_J : LINE_K;
            ST_STUFF:   line = ~nrzi_j ? LINE_J : LINE_K;
            ST_EOP_SE0: line = LINE_SE0;
            default:    line = LINE_J;
        endcase
    end

    assign dp_out  = line.dp;
    assign dm_out  = line.dm;
    assign tx_busy = (state != ST_IDLE) && (state != ST_DONE);
    assign tx_oe   = tx_busy;
    assign tx_done = (state == ST_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            shift   <= '0;
            len     <= '0;
            ones    <= '0;
            eop_cnt <= '0;
            nrzi_j  <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: if (accept) begin
                    shift   <= packet_TX;
                    len     <= len_in;
                    ones    <= '0;
                    eop_cnt <= '0;
                    nrzi_j  <= 1'b1;
                    state   <= (len_in == '0) ? ST_EOP_SE0 : ST_DATA;
                end
                ST_DATA: if (tick) begin
                    nrzi_j <= data_j;
                    shift  <= shift >> 1;
                    len    <= len_m1;
                    ones   <= ones_nxt;
                    // stuffing takes priority so a run ending on the last
                    // data bit still gets its zero before EOP
                    if (ones_nxt == 3'(STUFF_LIMIT))
                        state <= ST_STUFF;
                    else if (len_m1 == '0)
                        state <= ST_EOP_SE0;
                end
                ST_STUFF: if (tick) begin
                    nrzi_j <= ~nrzi_j;
                    ones   <= '0;
                    state  <= (len == '0) ? ST_EOP_SE0 : ST_DATA;
                end
                ST_EOP_SE0: if (tick) begin
                    if (eop_cnt == 2'(EOP_SE0_BITS - 1)) begin
                        eop_cnt <= '0;
                        state   <= ST_EOP_J;
                    end else begin
                        eop_cnt <= eop_cnt + 2'd1;
                    end
                end
                ST_EOP_J: if (tick) state <= ST_DONE;
                ST_DONE:  state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_usb_tx_bit_encoder.sv
module tb_usb_tx_bit_encoder;

    localparam int CPB  = 4;
    localparam int MAXB = 544;
    localparam int CW   = 10;
    localparam byte SJ  = "J";
    localparam byte SK  = "K";
    localparam byte S0  = "0";

    logic            clk = 1'b0;
    logic            rst;
    logic [MAXB-1:0] pkt;
    logic [CW-1:0]   cnt;
    logic            ld;
    logic            dp, dm, oe, busy, done;

    int n_tests = 0;
    int n_fail  = 0;
    byte sb[$];

    typedef struct {
        string       name;
        logic [15:0] data;
        int          count;
        string       exp;
    } vec_t;

    vec_t vecs[5];

    usb_tx_bit_encoder #(.CLKS_PER_BIT(CPB), .MAX_BITS(MAXB), .CNT_W(CW)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .packet_TX               (pkt),
        .packet_counter_TX       (cnt),
        .packet_load_complete_TX (ld),
        .dp_out                  (dp),
        .dm_out                  (dm),
        .tx_oe                   (oe),
        .tx_busy                 (busy),
        .tx_done                 (done)
    );

    always #5 clk = ~clk;

    function automatic byte sym();
        case ({dp, dm})
            2'b10:   return SJ;
            2'b01:   return SK;
            2'b00:   return S0;
            default: return "X";
        endcase
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) sb.push_back(s[i]);
    endtask

    // Reference wire sequence: stuff a zero after every six ones, then NRZI.
    task automatic push_model(input logic [MAXB-1:0] p, input int c);
        int  n    = (c > MAXB) ? MAXB : c;
        int  run  = 0;
        bit  lvl  = 1'b1;
        for (int i = 0; i < n; i++) begin
            if (p[i]) run++;
            else begin run = 0; lvl = ~lvl; end
            sb.push_back(lvl ? SJ : SK);
            if (run == 6) begin
                lvl = ~lvl;
                run = 0;
                sb.push_back(lvl ? SJ : SK);
            end
        end
        push_str("00J");
    endtask

    // Strobe a packet, check every cycle of every bit time against the
    // scoreboard, check the done pulse, then NRZI-decode and de-stuff what
    // was seen on the wire and compare it with the packet bits.
    task automatic run_pkt(input string nm, input logic [MAXB-1:0] p, input int c,
                           input string exp, input int inj);
        byte             obs[$];
        byte             e, s, prev;
        int              nb, run, nrec, mism, n, act_code, exp_code;
        bit              ok, b1;
        logic [MAXB-1:0] rec;
        @(negedge clk);
        pkt = p; cnt = CW'(c); ld = 1'b1;
        if (exp == "") push_model(p, c); else push_str(exp);
        nb = sb.size();
        for (int b = 0; b < nb; b++) begin
            e = sb.pop_front();
            ok = 1'b1;
            exp_code = {21'b0, 3'b110, e};
            act_code = exp_code;
            for (int k = 0; k < CPB; k++) begin
                @(negedge clk);
                if (b == 0 && k == 0) ld = 1'b0;
                s = sym();
                if (k == 0) obs.push_back(s);
                if (ok && (s != e || !oe || !busy || done)) begin
                    ok = 1'b0;
                    act_code = {21'b0, oe, busy, done, s};
                end
                if (b == inj && k == 0) begin
                    ld = 1'b1; pkt = ~p; cnt = CW'(MAXB - 3);
                end else if (b == inj && k == 1) begin
                    ld = 1'b0;
                end
            end
            chk($sformatf("%s bit%0d", nm, b), act_code, exp_code);
        end
        @(negedge clk);
        chk({nm, " done"}, {21'b0, done, oe, busy, sym()}, {21'b0, 3'b100, SJ});
        @(negedge clk);
        chk({nm, " idle"}, {29'b0, done, oe, busy}, 0);

        prev = SJ; run = 0; nrec = 0; mism = 0; rec = '0;
        for (int i = 0; i < nb - 3; i++) begin
            b1 = (obs[i] == prev);
            prev = obs[i];
            if (run == 6) begin
                if (b1) mism++;
                run = 0;
            end else begin
                if (nrec < MAXB) rec[nrec] = b1;
                nrec++;
                run = b1 ? run + 1 : 0;
            end
        end
        n = (c > MAXB) ? MAXB : c;
        chk({nm, " declen"}, nrec, n);
        for (int i = 0; i < n && i < nrec; i++) if (rec[i] !== p[i]) mism++;
        chk({nm, " decode"}, mism, 0);
    endtask

    initial begin
        logic [MAXB-1:0] rp;
        logic [MAXB-1:0] ack;
        int cyc;
        bit seen;

        vecs[0] = '{"ack",    16'hD280, 16, "KJKJKJKKJJKJJKKK00J"};
        vecs[1] = '{"stuff",  16'hFF80, 16, "KJKJKJKKKKKKKJJJJ00J"};
        vecs[2] = '{"trail",  16'hFF80, 13, "KJKJKJKKKKKKKJ00J"};
        vecs[3] = '{"c14",    16'hFF80, 14, "KJKJKJKKKKKKKJJ00J"};
        vecs[4] = '{"zero",   16'hD280, 0,  "00J"};
        ack = '0; ack[15:0] = 16'hD280;

        rst = 1'b1; ld = 1'b0; pkt = '0; cnt = '0;
        repeat (3) @(negedge clk);
        chk("reset", {27'b0, dp, dm, oe, busy, done}, 32'b10000);
        rst = 1'b0;

        foreach (vecs[i]) begin
            rp = '0; rp[15:0] = vecs[i].data;
            run_pkt(vecs[i].name, rp, vecs[i].count, vecs[i].exp, -1);
        end

        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < MAXB / 32; i++) rp[i*32 +: 32] = $urandom | $urandom;
            run_pkt($sformatf("rand%0d", r), rp, 1 + $urandom_range(0, 63), "", -1);
        end

        run_pkt("clamp600", '0, 600, "", -1);

        run_pkt("busy_strobe", ack, 16, "KJKJKJKKJJKJJKKK00J", 5);

        // reset in the middle of bit 5 of an ACK
        @(negedge clk); pkt = ack; cnt = 16; ld = 1'b1;
        @(negedge clk); ld = 1'b0;
        repeat (20) @(negedge clk);
        chk("pre-rst bit5", {23'b0, busy, sym()}, {23'b0, 1'b1, SJ});
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk("mid rst", {27'b0, dp, dm, oe, busy, done}, 32'b10000);
        seen = 1'b0;
        repeat (100) begin @(negedge clk); if (done || busy) seen = 1'b1; end
        chk("no done after rst", int'(seen), 0);
        run_pkt("after_rst", ack, 16, "KJKJKJKKJJKJJKKK00J", -1);

        // strobe in DONE ignored, strobe the next cycle accepted
        @(negedge clk); pkt = '0; cnt = 0; ld = 1'b1;
        @(negedge clk); ld = 1'b0;
        repeat (12) @(negedge clk);
        chk("c0 done cyc", {30'b0, done, busy}, 32'b10);
        pkt = ack; cnt = 16; ld = 1'b1;
        @(negedge clk);
        chk("done strobe ign", {30'b0, done, busy}, 0);
        @(negedge clk); ld = 1'b0;
        chk("post-done accept", {22'b0, oe, busy, sym()}, {22'b0, 2'b11, SK});
        cyc = 1;
        while (!done && cyc < 200) begin @(negedge clk); cyc++; end
        chk("ack done latency", cyc, 19 * CPB + 1);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
